// File: rtl/axis_mem_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream memory-write arbiter.
package axis_mem_arbiter_pkg;

    // Arbiter FSM encoding, kept stable for reuse by a read-side arbiter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned b = 1; b < 32; b++) begin
            if ((32'd1 << b) < value) begin
                result = b + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module axis_rr_picker
    import axis_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] ptr,
    output logic                      any,
    output logic [clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    int unsigned        src;
    int unsigned        sel;

    // Rotate so ptr sits at bit 0, priority-encode the lowest bit, rotate back.
    always_comb begin
        rot = '0;
        src = 0;
        sel = 0;
        any = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            src = j + 32'(ptr);
            if (src >= NUM_REQ) begin
                src = src - NUM_REQ;
            end
            rot[j] = req[src];
        end
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any = 1'b1;
                sel = 32'(j);
            end
        end
        src = sel + 32'(ptr);
        if (src >= NUM_REQ) begin
            src = src - NUM_REQ;
        end
        idx = IW'(src);
    end

endmodule

// File: rtl/axis_mem_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ AXI-Stream producers into one
// registered write stream; over-length packets are truncated and drained.
module axis_mem_arbiter
    import axis_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 4096
) (
    input  logic                              axis_aclk,
    input  logic                              axis_areset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] s01_axis_tstrb,
    input  logic [NUM_REQ-1:0]                s01_axis_tvalid,
    input  logic [NUM_REQ-1:0]                s01_axis_tlast,
    output logic [NUM_REQ-1:0]                s01_axis_tready,
    output logic [DATA_WIDTH-1:0]             m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m01_axis_tstrb,
    output logic                              m01_axis_tvalid,
    output logic                              m01_axis_tlast,
    input  logic                              m01_axis_tready,
    output logic [clog2(NUM_REQ)-1:0]         grant_id,
    output logic                              busy,
    output logic                              err_len
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned IW = clog2(NUM_REQ);
    localparam int unsigned CW = clog2(MAX_BEATS + 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       grant_d;
    logic                busy_d;
    logic                err_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]       cnt_inc;
    logic [IW-1:0]       ptr_after;

    logic                pick_any;
    logic [IW-1:0]       pick_idx;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [SW-1:0]         sel_strb;
    logic                  sel_valid;
    logic                  sel_last;

    logic                out_free;
    logic                load;
    logic                force_last;
    logic [NUM_REQ-1:0]  ready;

    axis_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (s01_axis_tvalid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Route the granted requester's beat to the arbiter core.
    always_comb begin
        sel_data  = '0;
        sel_strb  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                sel_data  = s01_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = s01_axis_tstrb[i*SW +: SW];
                sel_valid = s01_axis_tvalid[i];
                sel_last  = s01_axis_tlast[i];
            end
        end
    end

    assign out_free  = !m01_axis_tvalid || m01_axis_tready;
    assign cnt_inc   = beat_cnt_q + CW'(1);
    assign ptr_after = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    // Next-state, grant bookkeeping, beat counting and tready demux.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_id;
        busy_d     = busy;
        err_d      = 1'b0;
        beat_cnt_d = beat_cnt_q;
        ready      = '0;
        load       = 1'b0;
        force_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ready[grant_id] = out_free;
                if (sel_valid && out_free) begin
                    load = 1'b1;
                    if (sel_last) begin
                        ptr_d      = ptr_after;
                        beat_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (cnt_inc == CW'(MAX_BEATS)) begin
                        force_last = 1'b1;
                        err_d      = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        beat_cnt_d = cnt_inc;
                    end
                end
            end
            ST_DRAIN: begin
                ready[grant_id] = 1'b1;
                if (sel_valid && sel_last) begin
                    ptr_d   = ptr_after;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s01_axis_tready = ready;

    // Control state registers.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            err_len    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id   <= grant_d;
            busy       <= busy_d;
            err_len    <= err_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output register slice; payload holds while stalled.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            m01_axis_tvalid <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tlast  <= 1'b0;
        end else if (load) begin
            m01_axis_tvalid <= 1'b1;
            m01_axis_tdata  <= sel_data;
            m01_axis_tstrb  <= sel_strb;
            m01_axis_tlast  <= sel_last || force_last;
        end else if (m01_axis_tready) begin
            m01_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_mem_arbiter.sv
// Directed and randomized checks for axis_mem_arbiter (4 requesters, MAX_BEATS=4).
module tb_axis_mem_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk;
    logic              axis_areset;
    logic [NR*DW-1:0]  s_tdata;
    logic [NR*4-1:0]   s_tstrb;
    logic [NR-1:0]     s_tvalid;
    logic [NR-1:0]     s_tlast;
    logic [NR-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [3:0]        m_tstrb;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_len;

    axis_mem_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .axis_aclk       (clk),
        .axis_areset     (axis_areset),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tstrb  (s_tstrb),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tready (s_tready),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tlast  (m_tlast),
        .m01_axis_tready (m_tready),
        .grant_id        (grant_id),
        .busy            (busy),
        .err_len         (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } obeat_t;

    int          errors;
    int          checks;
    int          cyc;
    int          err_seen;
    int          src_acc;
    obeat_t      olog[$];
    logic [31:0] src_d [NR][64];
    logic        src_l [NR][64];
    int          src_wr [NR];
    int          src_rd [NR];
    bit          src_en [NR];
    bit          m_rdy;
    bit          rnd_en;
    bit          track;
    int          wait_cnt [NR];
    int          max_wait;

    task automatic push(input int r, input logic [31:0] d, input logic l);
        src_d[r][src_wr[r] % 64] = d;
        src_l[r][src_wr[r] % 64] = l;
        src_wr[r]++;
    endtask

    // One clock: drive at negedge, then log handshakes that the next posedge takes.
    task automatic step();
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            if (rnd_en) src_en[r] = ($urandom_range(0, 9) < 7);
            if (src_en[r] && src_rd[r] != src_wr[r]) begin
                s_tvalid[r]          = 1'b1;
                s_tdata[r*DW +: DW]  = src_d[r][src_rd[r] % 64];
                s_tlast[r]           = src_l[r][src_rd[r] % 64];
                s_tstrb[r*4 +: 4]    = 4'hF;
            end else begin
                s_tvalid[r]          = 1'b0;
                s_tdata[r*DW +: DW]  = '0;
                s_tlast[r]           = 1'b0;
                s_tstrb[r*4 +: 4]    = 4'h0;
            end
        end
        m_tready = m_rdy;
        #1;
        if (track) begin
            for (int r = 0; r < NR; r++) begin
                if (!s_tvalid[r] || s_tready[r] || src_d[r][src_rd[r] % 64][15:8] != 8'd0) begin
                    wait_cnt[r] = 0;
                end else begin
                    for (int o = 0; o < NR; o++) begin
                        if (o != r && s_tvalid[o] && s_tready[o] && s_tlast[o]) wait_cnt[r]++;
                    end
                    if (wait_cnt[r] > max_wait) max_wait = wait_cnt[r];
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (s_tvalid[r] && s_tready[r]) begin
                src_rd[r]++;
                src_acc++;
            end
        end
        if (m_tvalid && m_tready) olog.push_back('{m_tdata, m_tlast, cyc});
        if (err_len) err_seen++;
        cyc++;
    endtask

    task automatic clear_sources();
        for (int r = 0; r < NR; r++) begin
            src_wr[r]   = 0;
            src_rd[r]   = 0;
            src_en[r]   = 1'b0;
            wait_cnt[r] = 0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tstrb  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        axis_areset = 1'b1;
        clear_sources();
        m_rdy    = 1'b1;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        axis_areset = 1'b0;
        olog.delete();
        cyc      = 0;
        err_seen = 0;
        src_acc  = 0;
    endtask

    task automatic test_reset();
        obeat_t seen[$];
        @(negedge clk);
        axis_areset = 1'b1;
        s_tvalid = 4'($urandom);
        s_tlast  = 4'($urandom);
        s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        s_tstrb  = 16'($urandom);
        m_tready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tdata, m_tstrb, grant_id, busy, err_len, s_tready} !== '0)
            begin
            errors++;
            $display("FAIL reset_idle: got tvalid=%b tlast=%b tdata=%h strb=%h grant=%0d busy=%b err=%b tready=%b, want all 0",
                     m_tvalid, m_tlast, m_tdata, m_tstrb, grant_id, busy, err_len, s_tready);
        end
        do_reset();
        push(0, 32'h60, 1'b0);
        push(0, 32'h61, 1'b0);
        push(0, 32'h62, 1'b1);
        src_en[0] = 1'b1;
        repeat (3) step();
        checks++;
        if (!(m_tvalid && m_tdata == 32'h60)) begin
            errors++;
            $display("FAIL reset_pre: got tvalid=%b tdata=%h, want 1 / 00000060", m_tvalid, m_tdata);
        end
        axis_areset = 1'b1;
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tdata, busy, grant_id, s_tready} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got tvalid=%b tlast=%b tdata=%h busy=%b tready=%b, want all 0",
                     m_tvalid, m_tlast, m_tdata, busy, s_tready);
        end
        clear_sources();
        repeat (2) @(negedge clk);
        axis_areset = 1'b0;
        olog.delete();
        repeat (4) step();
        seen = olog;
        checks++;
        if (seen.size() != 0) begin
            errors++;
            $display("FAIL reset_no_tlast: got %0d output beats after reset, want 0", seen.size());
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_d [3];
        logic        exp_l [3];
        exp_d = '{32'hA0, 32'hA1, 32'hA2};
        exp_l = '{1'b0, 1'b0, 1'b1};
        do_reset();
        push(0, 32'hA0, 1'b0);
        push(0, 32'hA1, 1'b0);
        push(0, 32'hA2, 1'b1);
        src_en[0] = 1'b1;
        repeat (2) step();
        checks++;
        if (!(busy === 1'b1 && grant_id === 2'd0)) begin
            errors++;
            $display("FAIL single_grant: got busy=%b grant=%0d, want 1 / 0", busy, grant_id);
        end
        repeat (4) step();
        checks++;
        if (olog.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d beats, want 3", olog.size());
        end
        for (int i = 0; i < 3 && i < olog.size(); i++) begin
            checks++;
            if (olog[i].d !== exp_d[i] || olog[i].l !== exp_l[i] || olog[i].c != i + 2) begin
                errors++;
                $display("FAIL single_beat%0d: got d=%h l=%b cyc=%0d, want d=%h l=%b cyc=%0d",
                         i, olog[i].d, olog[i].l, olog[i].c, exp_d[i], exp_l[i], i + 2);
            end
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b grant=%0d tvalid=%b, want 0 / 0 / 0",
                     busy, grant_id, m_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [5];
        exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        do_reset();
        for (int r = 0; r < NR; r++) begin
            push(r, 32'hB0 + 32'(r), 1'b1);
            src_en[r] = 1'b1;
        end
        push(0, 32'hB4, 1'b1);
        repeat (12) step();
        checks++;
        if (olog.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, want 5", olog.size());
        end
        for (int i = 0; i < 5 && i < olog.size(); i++) begin
            checks++;
            if (olog[i].d !== exp_d[i] || olog[i].l !== 1'b1 || olog[i].c != 2 + 2 * i) begin
                errors++;
                $display("FAIL b2b_pkt%0d: got d=%h l=%b cyc=%0d, want d=%h l=1 cyc=%0d",
                         i, olog[i].d, olog[i].l, olog[i].c, exp_d[i], 2 + 2 * i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [6];
        logic        exp_l [6];
        exp_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        push(1, 32'hC0, 1'b0);
        push(1, 32'hC1, 1'b0);
        push(1, 32'hC2, 1'b0);
        push(1, 32'hC3, 1'b1);
        push(2, 32'hD0, 1'b0);
        push(2, 32'hD1, 1'b1);
        src_en[1] = 1'b1;
        src_en[2] = 1'b1;
        for (int s = 0; s < 14; s++) begin
            m_rdy = !(s >= 3 && s <= 5);
            step();
            if (s >= 3 && s <= 5) begin
                checks++;
                if (!(m_tvalid === 1'b1 && m_tdata === 32'hC1 && m_tlast === 1'b0 && s_tready === 4'b0000)) begin
                    errors++;
                    $display("FAIL stall_hold%0d: got tvalid=%b tdata=%h tlast=%b tready=%b, want 1 / 000000c1 / 0 / 0000",
                             s, m_tvalid, m_tdata, m_tlast, s_tready);
                end
            end
        end
        m_rdy = 1'b1;
        checks++;
        if (olog.size() != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, want 6", olog.size());
        end
        for (int i = 0; i < 6 && i < olog.size(); i++) begin
            checks++;
            if (olog[i].d !== exp_d[i] || olog[i].l !== exp_l[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, olog[i].d, olog[i].l, exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL exact_max_no_err: got %0d err_len cycles, want 0", err_seen);
        end
    endtask

    task automatic test_truncate();
        logic [31:0] exp_d [5];
        logic        exp_l [5];
        exp_d = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hF0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int b = 0; b < 6; b++) push(0, 32'hE0 + 32'(b), b == 5);
        push(1, 32'hF0, 1'b1);
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        repeat (14) step();
        checks++;
        if (olog.size() != 5) begin
            errors++;
            $display("FAIL trunc_count: got %0d beats, want 5", olog.size());
        end
        for (int i = 0; i < 5 && i < olog.size(); i++) begin
            checks++;
            if (olog[i].d !== exp_d[i] || olog[i].l !== exp_l[i]) begin
                errors++;
                $display("FAIL trunc_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, olog[i].d, olog[i].l, exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (err_seen != 1) begin
            errors++;
            $display("FAIL trunc_err: got %0d err_len cycles, want 1", err_seen);
        end
        checks++;
        if (src_rd[0] != 6 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL trunc_drain: got req0 consumed=%0d grant=%0d, want 6 / 1", src_rd[0], grant_id);
        end
    endtask

    task automatic test_random();
        int   gen_pk [NR];
        int   exp_pk [NR];
        int   exp_bt [NR];
        bit   in_pkt;
        int   cur;
        int   budget;
        int   id, pk, bt, ln;
        bit   ok;
        do_reset();
        for (int r = 0; r < NR; r++) begin
            gen_pk[r] = 0;
            exp_pk[r] = 0;
            exp_bt[r] = 0;
        end
        max_wait = 0;
        track    = 1'b1;
        rnd_en   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (src_wr[r] - src_rd[r] < 8) begin
                    ln = $urandom_range(1, 4);
                    for (int b = 0; b < ln; b++)
                        push(r, {8'(r), 8'(gen_pk[r]), 8'(b), 8'(ln)}, b == ln - 1);
                    gen_pk[r]++;
                end
            end
            m_rdy = ($urandom_range(0, 9) < 7);
            step();
        end
        rnd_en = 1'b0;
        m_rdy  = 1'b1;
        for (int r = 0; r < NR; r++) src_en[r] = 1'b1;
        budget = 0;
        while (budget < 400 && (busy || m_tvalid || src_rd[0] != src_wr[0] || src_rd[1] != src_wr[1]
                                || src_rd[2] != src_wr[2] || src_rd[3] != src_wr[3])) begin
            step();
            budget++;
        end
        step();
        track = 1'b0;
        checks++;
        if (budget >= 400) begin
            errors++;
            $display("FAIL rand_drain_timeout: still busy after %0d cycles, want idle", budget);
        end
        checks++;
        if (olog.size() != src_acc || src_acc < 100) begin
            errors++;
            $display("FAIL rand_beat_total: got %0d out beats, want %0d accepted (>=100)", olog.size(), src_acc);
        end
        in_pkt = 1'b0;
        cur    = 0;
        foreach (olog[i]) begin
            id = int'(olog[i].d[31:24]);
            pk = int'(olog[i].d[23:16]);
            bt = int'(olog[i].d[15:8]);
            ln = int'(olog[i].d[7:0]);
            ok = (id < NR);
            if (ok) begin
                ok = !(in_pkt && id != cur) && bt == exp_bt[id] && pk == (exp_pk[id] % 256)
                     && olog[i].l == (bt == ln - 1);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_beat%0d: got id=%0d pkt=%0d beat=%0d len=%0d last=%b, want owner=%0d pkt=%0d beat=%0d",
                         i, id, pk, bt, ln, olog[i].l, in_pkt ? cur : id,
                         id < NR ? exp_pk[id] % 256 : -1, id < NR ? exp_bt[id] : -1);
                break;
            end
            if (olog[i].l) begin
                in_pkt     = 1'b0;
                exp_bt[id] = 0;
                exp_pk[id]++;
            end else begin
                in_pkt = 1'b1;
                cur    = id;
                exp_bt[id]++;
            end
        end
        checks++;
        if (max_wait > NR) begin
            errors++;
            $display("FAIL rand_starvation: got %0d packets passed a waiting requester, want <= %0d", max_wait, NR);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        err_seen    = 0;
        src_acc     = 0;
        rnd_en      = 1'b0;
        track       = 1'b0;
        max_wait    = 0;
        m_rdy       = 1'b1;
        m_tready    = 1'b1;
        axis_areset = 1'b1;
        clear_sources();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_truncate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
